// File: rtl/accum_bank_pkg.sv
// Shared configuration for the partial-sum accumulator bank.
package accum_bank_pkg;
    // Default partial-sum width coming out of the systolic array.
    localparam int P_BITWIDTH     = 16;
    // Default number of array columns (lanes).
    localparam int N_COLS_DEFAULT = 4;

    // Bank-level control state.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } acc_state_e;
endpackage

// File: rtl/accum_lane.sv
// One accumulator column: DEPTH rows of signed partial sums, an in-place
// overwrite/accumulate write port, a combinational read port and a sticky
// overflow flag.
module accum_lane
    import accum_bank_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DWIDTH   = P_BITWIDTH,
    parameter int SATURATE = 1,
    parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              first,
    input  logic              ovf_clr,
    input  logic [AW-1:0]     wr_addr,
    input  logic [AW-1:0]     rd_addr,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              ovf
);

    localparam logic [DWIDTH-1:0] POS_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] NEG_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    logic [DWIDTH-1:0] mem_reg [DEPTH];
    logic              ovf_reg;
    logic [DWIDTH-1:0] cur_row;
    logic [DWIDTH:0]   sum_next;
    logic [DWIDTH-1:0] wr_data_next;
    logic              wr_ovf_next;

    assign cur_row = mem_reg[wr_addr];
    assign dout    = mem_reg[rd_addr];
    assign ovf     = ovf_reg;

    // Compute the value to store: first-pass data, or a one-bit-wider signed
    // sum that is clamped or wrapped when it leaves the DWIDTH range.
    always_comb begin
        sum_next     = {cur_row[DWIDTH-1], cur_row} + {din[DWIDTH-1], din};
        wr_data_next = sum_next[DWIDTH-1:0];
        wr_ovf_next  = 1'b0;
        if (first) begin
            wr_data_next = din;
        end else if (sum_next[DWIDTH] != sum_next[DWIDTH-1]) begin
            wr_ovf_next = 1'b1;
            if (SATURATE != 0) begin
                wr_data_next = sum_next[DWIDTH] ? NEG_MIN : POS_MAX;
            end
        end
    end

    // Row storage; cleared on reset so a fresh drain reads zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_addr] <= wr_data_next;
        end
    end

    // Sticky overflow flag, cleared when a tile has been fully drained.
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            ovf_reg <= 1'b0;
        end else if (wr_en && wr_ovf_next) begin
            ovf_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/accum_bank.sv
// Multi-column partial-sum accumulator bank: N_COLS lanes written in lockstep
// from one input beat, drained row by row through a registered ready/valid port.
module accum_bank
    import accum_bank_pkg::*;
#(
    parameter int N_COLS   = N_COLS_DEFAULT,
    parameter int DEPTH    = 16,
    parameter int DWIDTH   = P_BITWIDTH,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic [N_COLS*DWIDTH-1:0] in_data,
    input  logic                     drain_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_COLS*DWIDTH-1:0] out_data,
    output logic                     done,
    output logic [N_COLS-1:0]        ovf
);

    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    acc_state_e               state_reg, state_next;
    logic [AW-1:0]            wr_ptr_reg;
    logic [AW-1:0]            rd_ptr_reg;
    logic                     issued_all_reg;
    logic                     out_valid_reg;
    logic [N_COLS*DWIDTH-1:0] out_data_reg;
    logic                     done_reg;
    logic [N_COLS*DWIDTH-1:0] lane_dout;

    logic accept;
    logic load_en;
    logic last_hs;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign done      = done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_COLS; gi++) begin : g_lane
            accum_lane #(
                .DEPTH   (DEPTH),
                .DWIDTH  (DWIDTH),
                .SATURATE(SATURATE),
                .AW      (AW)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .wr_en  (accept),
                .first  (in_first),
                .ovf_clr(last_hs),
                .wr_addr(wr_ptr_reg),
                .rd_addr(rd_ptr_reg),
                .din    (in_data[gi*DWIDTH +: DWIDTH]),
                .dout   (lane_dout[gi*DWIDTH +: DWIDTH]),
                .ovf    (ovf[gi])
            );
        end
    endgenerate

    // Handshake decode and next-state logic. rd_ptr runs one row ahead of the
    // consumer: it names the next row to load into the output register, and
    // issued_all marks that the register now holds the final row.
    always_comb begin
        accept     = in_valid && (state_reg == IDLE);
        load_en    = (state_reg == DRAIN) && (!out_valid_reg || out_ready) && !issued_all_reg;
        last_hs    = (state_reg == DRAIN) && out_valid_reg && out_ready && issued_all_reg;
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (drain_req) state_next = DRAIN;
            DRAIN:   if (last_hs)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Write/read pointers; a drain request restarts both at row 0, abandoning
    // any partially written pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            issued_all_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE) begin
                if (drain_req) begin
                    wr_ptr_reg     <= '0;
                    rd_ptr_reg     <= '0;
                    issued_all_reg <= 1'b0;
                end else if (accept) begin
                    wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
                end
            end
            if (load_en) begin
                rd_ptr_reg     <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
                issued_all_reg <= (rd_ptr_reg == LAST);
            end
        end
    end

    // Output register and end-of-tile pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= last_hs;
            if (load_en) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= lane_dout;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accum_bank.sv
// Scoreboard bench for accum_bank: a saturating and a wrapping instance share
// the same stimulus; a monitor pops expected rows on every output handshake.
module tb_accum_bank;
    localparam int NC = 4;
    localparam int DP = 4;
    localparam int DW = 16;
    localparam int BW = NC * DW;

    typedef struct {
        logic [BW-1:0] sat;
        logic [BW-1:0] wrap;
    } exp_row_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          drain_req = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready, out_valid, done;
    logic [BW-1:0] out_data;
    logic [NC-1:0] ovf;
    logic          w_in_ready, w_out_valid, w_done;
    logic [BW-1:0] w_out_data;
    logic [NC-1:0] w_ovf;

    exp_row_t exp_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    int       done_cnt = 0;
    logic          stall_seen = 1'b0;
    logic [BW-1:0] stall_data = '0;
    logic [BW-1:0] w_stall_data = '0;

    always #5 clk = ~clk;

    accum_bank #(.N_COLS(NC), .DEPTH(DP), .DWIDTH(DW), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_data(in_data), .drain_req(drain_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done), .ovf(ovf)
    );

    accum_bank #(.N_COLS(NC), .DEPTH(DP), .DWIDTH(DW), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_first(in_first), .in_data(in_data), .drain_req(drain_req),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .done(w_done), .ovf(w_ovf)
    );

    function automatic logic [BW-1:0] pack4(int a, int b, int c, int d);
        logic [BW-1:0] r;
        r = {d[15:0], c[15:0], b[15:0], a[15:0]};
        return r;
    endfunction

    task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(logic first, logic [BW-1:0] d);
        in_valid = 1'b1;
        in_first = first;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_row(logic [BW-1:0] s, logic [BW-1:0] w);
        exp_row_t e;
        e.sat  = s;
        e.wrap = w;
        exp_q.push_back(e);
    endtask

    task automatic pulse_drain();
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
    endtask

    // Wait (bounded) for one done pulse, then confirm the tile fully drained.
    task automatic wait_done(string name, int start_cnt);
        int budget = 40;
        while (done_cnt == start_cnt && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        repeat (3) tick();
        check({name, "_done_count"}, BW'(done_cnt - start_cnt), BW'(1));
        check({name, "_rows_left"}, BW'(exp_q.size()), BW'(0));
    endtask

    // Monitor: compare each handshaken row, hold stability under backpressure
    // and count done pulses.
    always @(negedge clk) begin
        exp_row_t e;
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stall_seen && out_valid) begin
                check("hold_sat", out_data, stall_data);
                check("hold_wrap", w_out_data, w_stall_data);
            end
            stall_seen   = out_valid && !out_ready;
            stall_data   = out_data;
            w_stall_data = w_out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_row: got %h expected no row", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("row_sat", out_data, e.sat);
                    check("row_wrap", w_out_data, e.wrap);
                    $display("row %h / %h", out_data, w_out_data);
                end
            end
        end
    end

    initial begin
        int d0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset then idle.
        repeat (10) begin
            @(negedge clk);
            check("idle_ctrl", BW'({in_ready, out_valid, done, ovf}), BW'(7'b1000000));
            check("idle_data", out_data, '0);
            tick();
        end

        // Two-pass accumulate.
        for (int r = 0; r < DP; r++) beat(1'b1, pack4(10*r, 10*r+1, 10*r+2, 10*r+3));
        for (int r = 0; r < DP; r++) beat(1'b0, pack4(1, 1, 1, 1));
        for (int r = 0; r < DP; r++)
            push_row(pack4(10*r+1, 10*r+2, 10*r+3, 10*r+4), pack4(10*r+1, 10*r+2, 10*r+3, 10*r+4));
        d0 = done_cnt;
        pulse_drain();
        wait_done("two_pass", d0);
        check("two_pass_ovf", BW'(ovf), BW'(0));

        // Saturation versus wrap.
        beat(1'b1, pack4(32000, 0, 0, 0));
        for (int r = 1; r < DP; r++) beat(1'b1, '0);
        beat(1'b0, pack4(1000, 0, 0, 0));
        for (int r = 1; r < DP; r++) beat(1'b0, '0);
        @(negedge clk);
        check("sat_ovf", BW'(ovf), BW'(4'b0001));
        check("wrap_ovf", BW'(w_ovf), BW'(4'b0001));
        tick();
        push_row(pack4(32767, 0, 0, 0), pack4(-32536, 0, 0, 0));
        for (int r = 1; r < DP; r++) push_row('0, '0);
        d0 = done_cnt;
        pulse_drain();
        wait_done("sat", d0);
        check("sat_ovf_cleared", BW'({ovf, w_ovf}), BW'(0));

        // Backpressure on row 1.
        for (int r = 0; r < DP; r++) beat(1'b1, pack4(100*r, 100*r+1, 100*r+2, 100*r+3));
        for (int r = 0; r < DP; r++) push_row(pack4(100*r, 100*r+1, 100*r+2, 100*r+3),
                                              pack4(100*r, 100*r+1, 100*r+2, 100*r+3));
        d0 = done_cnt;
        pulse_drain();
        tick();
        tick();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", BW'({in_ready, out_valid}), BW'(2'b01));
            tick();
        end
        out_ready = 1'b1;
        wait_done("backpressure", d0);

        // Beat and drain request in the same cycle; second request ignored.
        for (int r = 0; r < DP; r++) beat(1'b1, pack4(20+4*r, 21+4*r, 22+4*r, 23+4*r));
        for (int r = 0; r < DP-1; r++) beat(1'b0, pack4(5, 5, 5, 5));
        for (int r = 0; r < DP; r++) push_row(pack4(25+4*r, 26+4*r, 27+4*r, 28+4*r),
                                              pack4(25+4*r, 26+4*r, 27+4*r, 28+4*r));
        d0 = done_cnt;
        in_valid  = 1'b1;
        in_first  = 1'b0;
        in_data   = pack4(5, 5, 5, 5);
        drain_req = 1'b1;
        tick();
        in_valid  = 1'b0;
        drain_req = 1'b0;
        tick();
        pulse_drain();
        wait_done("simul", d0);

        // Reset after two drained rows.
        for (int r = 0; r < DP; r++) beat(1'b1, pack4(7, 7, 7, 7));
        push_row(pack4(7, 7, 7, 7), pack4(7, 7, 7, 7));
        push_row(pack4(7, 7, 7, 7), pack4(7, 7, 7, 7));
        d0 = done_cnt;
        pulse_drain();
        tick();
        tick();
        tick();
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        @(negedge clk);
        check("rst_mid_ctrl", BW'({in_ready, out_valid, done}), BW'(3'b100));
        rst       = 1'b0;
        out_ready = 1'b1;
        check("rst_mid_rows_left", BW'(exp_q.size()), BW'(0));
        repeat (5) tick();
        check("rst_mid_no_done", BW'(done_cnt - d0), BW'(0));
        for (int r = 0; r < DP; r++) push_row('0, '0);
        d0 = done_cnt;
        pulse_drain();
        wait_done("after_rst", d0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/accum_bank.md
# accum_bank

Multi-column partial-sum accumulator placed below the systolic array; a parametrised successor to the single-lane accumulator buffer. Each of N_COLS lanes holds DEPTH rows of partial sums, overwrites or accumulates incoming beats in place, and drains the finished tile through a ready/valid port. Adds row addressing with wrap-around, optional saturation, overflow reporting and a drain state machine.

## Interface
- N_COLS, 4, number of independent lanes (array columns)
- DEPTH, 16, rows per lane; power of two, ≥1
- DWIDTH, P_BITWIDTH, signed partial-sum width
- SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_first  in  1  beat belongs to first K-pass: store in_data, do not add
- in_data  in  N_COLS*DWIDTH  lane c at bits [c*DWIDTH +: DWIDTH], signed
- drain_req  in  1  single-cycle pulse: begin tile readout
- out_valid  out  1  out_data holds a drained row
- out_ready  in  1  consumer accepts row
- out_data  out  N_COLS*DWIDTH  drained row, same packing as in_data
- done  out  1  one-cycle pulse after last row handshake
- ovf  out  N_COLS  sticky per-lane overflow flag

## Operation
- States: IDLE (accepting beats), DRAIN (reading out). Reset → IDLE.
- in_ready = (state == IDLE). Beats are ignored while rst is high.
- Accepted beat writes row wr_ptr of every lane: in_first ? in_data[c] : mem[c][wr_ptr] + in_data[c]. wr_ptr then increments, wrapping DEPTH-1 → 0.
- Add is DWIDTH+1 bits signed. Overflow (result outside DWIDTH range) sets ovf[c]. SATURATE=1 stores 2^(DWIDTH-1)-1 or -2^(DWIDTH-1); SATURATE=0 stores the low DWIDTH bits.
- in_first beats never overflow.
- IDLE + drain_req → DRAIN with rd_ptr=0 and wr_ptr=0 (a partial pass is abandoned).
- DRAIN: row rd_ptr is presented; each out handshake advances rd_ptr. The handshake on row DEPTH-1 → IDLE, pulses done, and clears ovf.
- drain_req in DRAIN: ignored. in_valid with drain_req in the same cycle: the beat is accepted first, and DRAIN starts next cycle.
- Memory contents persist across drains; the next tile must start with in_first beats.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, out_data=0, done=0, ovf=0, wr_ptr=rd_ptr=0, all memory rows=0.
- Write latency: a beat accepted at edge k is visible to a beat at edge k+1 on the same row (DEPTH=1 back-to-back accumulation is legal). Memory read is combinational.
- Drain latency: drain_req sampled at edge 0. out_valid=1 with row 0 after edge 1.
- out_data/out_valid are registered, loaded when !out_valid || out_ready. With out_ready held high, one row per cycle: DEPTH rows over edges 1..DEPTH.
- out_data is stable while out_valid && !out_ready.
- done is high for the one cycle after the final handshake edge. in_ready returns to 1 in that same cycle.
- rst mid-DRAIN: the next cycle is IDLE with all reset values. No done pulse, no partial output.

## Structure
- Config package gains the typedef acc_state_e {IDLE, DRAIN} and the default N_COLS constant. P_BITWIDTH stays there.
- Sub-module accum_lane: one column's DEPTH×DWIDTH register array, the adder, saturation logic and its ovf bit. It takes wr_en, first, wr_addr, rd_addr and din, and outputs dout and ovf.
- accum_bank instantiates N_COLS lanes with a generate loop and owns the FSM, pointers and output register.

## Test plan
Configuration N_COLS=4, DEPTH=4, DWIDTH=16, SATURATE=1 unless stated.
- Reset then idle: in_ready=1; out_valid=0, done=0, ovf=0 for 10 cycles.
- Two-pass accumulate: pass 1 (in_first=1) writes rows 0..3 with lane c = 10*r+c. Pass 2 (in_first=0) adds 1 to every lane. drain_req with out_ready=1 → rows appear on 4 consecutive cycles with lane c = 10*r+c+1, then done is pulsed once.
- Saturation: row 0 written with 32000, then 1000 added → stored 32767 and ovf[0]=1. Rerun with SATURATE=0 → stored -32536.
- Backpressure: during the drain, out_ready=0 for 3 cycles on row 1 → out_data holds row 1 unchanged, no row is skipped or duplicated, and in_ready=0 throughout.
- Simultaneous in_valid and drain_req on row 3 of pass 2 → the beat is accumulated, and row 3 drains the updated value. A second drain_req during DRAIN has no effect.
- rst asserted after 2 drained rows → next cycle: out_valid=0, in_ready=1, no done pulse, and a subsequent drain returns all zeros.
